// File: rtl/verdict_collector.sv
// Timestamps monitor verdicts from streams A/B and buffers them in a dual-write FWFT FIFO.
// Optional saturating drop counter enabled by defining VERDICT_COLLECTOR_DROP_CNT_EN.
module verdict_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 64,
    parameter int unsigned TS_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic signed [DW-1:0]   in_a,
    input  logic                   in_a_vld,
    input  logic signed [DW-1:0]   in_b,
    input  logic                   in_b_vld,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_tag,
    output logic [TS_W-1:0]        out_ts,
    output logic signed [DW-1:0]   out_value,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic            mem_tag   [DEPTH];
    logic [TS_W-1:0] mem_ts    [DEPTH];
    logic [DW-1:0]   mem_value [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_idx_b;
    logic [LW-1:0]   level_q, level_d, free;
    logic [TS_W-1:0] ts_q;
    logic            overflow_q, overflow_d;
    logic            push_a, push_b, acc_a, acc_b, pop;
    logic [1:0]      drops;

    logic            last_tag_q;
    logic [TS_W-1:0] last_ts_q;
    logic [DW-1:0]   last_value_q;

    always_comb begin
        push_a = en & in_a_vld;
        push_b = en & in_b_vld;
        pop    = out_valid & out_ready;
        free   = LW'(DEPTH) - level_q + LW'(pop);
        // B only fits if there is room left after A has taken its slot
        acc_a  = push_a & (free != '0);
        acc_b  = push_b & (free > LW'(acc_a));
        drops  = {1'b0, push_a & ~acc_a} + {1'b0, push_b & ~acc_b};
        wr_idx_b = wr_ptr_q + PW'(acc_a);

        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
        level_d    = level_q + LW'(acc_a) + LW'(acc_b) - LW'(pop);
        overflow_d = overflow_q | (drops != 2'd0);
        if (clr) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_a && !clr) begin
            mem_tag[wr_ptr_q]   <= 1'b0;
            mem_ts[wr_ptr_q]    <= ts_q;
            mem_value[wr_ptr_q] <= in_a;
        end
        if (acc_b && !clr) begin
            mem_tag[wr_idx_b]   <= 1'b1;
            mem_ts[wr_idx_b]    <= ts_q;
            mem_value[wr_idx_b] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            ts_q         <= '0;
            last_tag_q   <= 1'b0;
            last_ts_q    <= '0;
            last_value_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            if (en) begin
                ts_q <= ts_q + TS_W'(1);
            end
            // Remember the displayed head so outputs hold once the FIFO empties
            last_tag_q   <= out_tag;
            last_ts_q    <= out_ts;
            last_value_q <= out_value;
        end
    end

    always_comb begin
        out_valid = (level_q != '0);
        out_tag   = last_tag_q;
        out_ts    = last_ts_q;
        out_value = last_value_q;
        if (out_valid) begin
            out_tag   = mem_tag[rd_ptr_q];
            out_ts    = mem_ts[rd_ptr_q];
            out_value = mem_value[rd_ptr_q];
        end
    end

    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drops);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_verdict_collector.sv
// Self-checking bench for verdict_collector: scoreboard queue plus per-scenario tasks.
// A second instance with TS_W=4 shares the stimulus to observe timestamp wrap.
module tb_verdict_collector;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    typedef struct packed {
        logic        tag;
        logic [31:0] ts;
        logic [63:0] value;
    } rec_t;

    logic               clk = 1'b0;
    logic               rst, en, clr, in_a_vld, in_b_vld, out_ready;
    logic signed [63:0] in_a, in_b;
    logic               out_valid, out_tag, overflow;
    logic [31:0]        out_ts;
    logic signed [63:0] out_value;
    logic [LW-1:0]      level;
    logic               w_out_valid, w_out_tag, w_overflow;
    logic [3:0]         w_out_ts;
    logic signed [63:0] w_out_value;
    logic [LW-1:0]      w_level;
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
    logic [15:0]        drop_cnt, w_drop_cnt;
`endif

    rec_t        q[$];
    rec_t        last_m;
    logic [31:0] ts_m;
    logic        ovf_m;
    int          drop_m;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    verdict_collector #(.DEPTH(DEPTH), .DW(64), .TS_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_a(in_a), .in_a_vld(in_a_vld), .in_b(in_b), .in_b_vld(in_b_vld),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_ts(out_ts), .out_value(out_value), .level(level), .overflow(overflow)
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    verdict_collector #(.DEPTH(DEPTH), .DW(64), .TS_W(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .in_a(in_a), .in_a_vld(in_a_vld), .in_b(in_b), .in_b_vld(in_b_vld),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_tag(w_out_tag),
        .out_ts(w_out_ts), .out_value(w_out_value), .level(w_level), .overflow(w_overflow)
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        , .drop_cnt(w_drop_cnt)
`endif
    );

    // Scoreboard monitor: compares head/level/overflow every cycle, pops on handshake
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (level !== LW'(q.size()) || w_level !== LW'(q.size())) begin
                errors++;
                $display("FAIL level: got %0d/%0d want %0d", level, w_level, q.size());
            end
            checks++;
            if (overflow !== ovf_m || w_overflow !== ovf_m) begin
                errors++;
                $display("FAIL overflow: got %0b want %0b", overflow, ovf_m);
            end
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
            checks++;
            if (drop_cnt !== 16'(drop_m)) begin
                errors++;
                $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, drop_m);
            end
`endif
            checks++;
            if (q.size() != 0) begin
                if (out_valid !== 1'b1 || w_out_valid !== 1'b1 || out_tag !== q[0].tag ||
                    out_ts !== q[0].ts || out_value !== q[0].value || w_out_ts !== q[0].ts[3:0]) begin
                    errors++;
                    $display("FAIL head: got v=%0b tag=%0b ts=%0d wts=%0d val=%0h want tag=%0b ts=%0d val=%0h",
                             out_valid, out_tag, out_ts, w_out_ts, out_value,
                             q[0].tag, q[0].ts, q[0].value);
                end
                last_m = q[0];
                if (out_ready && !clr) void'(q.pop_front());
            end else begin
                if (out_valid !== 1'b0 || out_tag !== last_m.tag || out_ts !== last_m.ts ||
                    out_value !== last_m.value || w_out_ts !== last_m.ts[3:0]) begin
                    errors++;
                    $display("FAIL idle_hold: got v=%0b tag=%0b ts=%0d val=%0h want v=0 tag=%0b ts=%0d val=%0h",
                             out_valid, out_tag, out_ts, out_value,
                             last_m.tag, last_m.ts, last_m.value);
                end
            end
        end
    end

    // Called at posedge+1 with inputs already set; models the next edge
    task automatic step();
        int  free;
        bit  a_ok, b_ok;
        int  drops;
        @(negedge clk);
        #2;
        if (clr) begin
            q.delete();
            ovf_m  = 1'b0;
            drop_m = 0;
        end else if (en) begin
            free  = DEPTH - q.size();
            a_ok  = in_a_vld && free >= 1;
            b_ok  = in_b_vld && free >= (a_ok ? 2 : 1);
            drops = 0;
            if (a_ok) q.push_back('{tag: 1'b0, ts: ts_m, value: in_a});
            else if (in_a_vld) drops++;
            if (b_ok) q.push_back('{tag: 1'b1, ts: ts_m, value: in_b});
            else if (in_b_vld) drops++;
            if (drops != 0) ovf_m = 1'b1;
            drop_m = (drop_m + drops > 65535) ? 65535 : drop_m + drops;
        end
        @(posedge clk);
        #1;
        if (en) ts_m = ts_m + 1;
    endtask

    task automatic model_init();
        q.delete();
        last_m = '0;
        ts_m   = '0;
        ovf_m  = 1'b0;
        drop_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_a_vld = 1'b0; in_b_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || out_tag !== 1'b0 ||
            out_ts !== '0 || out_value !== '0) begin
            errors++;
            $display("FAIL reset: got v=%0b lvl=%0d ovf=%0b tag=%0b ts=%0d val=%0h want all 0",
                     out_valid, level, overflow, out_tag, out_ts, out_value);
        end
        rst = 1'b1;
        model_init();
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        en = 1'b1; out_ready = 1'b1;
        in_a = 64'sd1; in_a_vld = 1'b1;
        step();
        in_a_vld = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 1'b0 || out_ts !== 32'd0 || out_value !== 64'sd1) begin
            errors++;
            $display("FAIL basic_head: got v=%0b tag=%0b ts=%0d val=%0d want 1/0/0/1",
                     out_valid, out_tag, out_ts, out_value);
        end
        step();
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL basic_level: got %0d want 0", level);
        end
        step();
        step();
    endtask

    task automatic test_dual();
        out_ready = 1'b0;
        in_a = 64'sd2; in_b = -64'sd3; in_a_vld = 1'b1; in_b_vld = 1'b1;
        step();
        in_a_vld = 1'b0; in_b_vld = 1'b0;
        checks++;
        if (level !== 4'd2 || out_tag !== 1'b0 || out_value !== 64'sd2 || out_ts !== 32'd4) begin
            errors++;
            $display("FAIL dual_first: got lvl=%0d tag=%0b val=%0d ts=%0d want 2/0/2/4",
                     level, out_tag, out_value, out_ts);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (level !== 4'd1 || out_tag !== 1'b1 || out_value !== -64'sd3 || out_ts !== 32'd4) begin
            errors++;
            $display("FAIL dual_second: got lvl=%0d tag=%0b val=%0d ts=%0d want 1/1/-3/4",
                     level, out_tag, out_value, out_ts);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            in_a = 64'(i); in_a_vld = 1'b1;
            step();
        end
        in_a = 64'sd8; in_b = 64'sd9; in_b_vld = 1'b1;
        step();
        in_a_vld = 1'b0; in_b_vld = 1'b0;
        checks++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full: got lvl=%0d ovf=%0b want 8/1", level, overflow);
        end
`ifdef VERDICT_COLLECTOR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt);
        end
`endif
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        in_a = 64'sd10; in_a_vld = 1'b1;
        step();
        in_a_vld = 1'b0; out_ready = 1'b0;
        checks++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got lvl=%0d ovf=%0b want 8/1", level, overflow);
        end
        out_ready = 1'b1;
        repeat (8) step();
        checks++;
        if (level !== '0 || out_value !== 64'sd10) begin
            errors++;
            $display("FAIL full_drain: got lvl=%0d last=%0d want 0/10", level, out_value);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] t0;
        out_ready = 1'b0;
        t0 = ts_m;
        for (int i = 0; i < 3; i++) begin
            in_a = 64'(20 + i); in_a_vld = 1'b1;
            step();
        end
        in_a_vld = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_tag !== 1'b0 || out_value !== 64'sd20 || out_ts !== t0 || level !== 4'd3) begin
                errors++;
                $display("FAIL stall_%0d: got tag=%0b val=%0d ts=%0d lvl=%0d want 0/20/%0d/3",
                         c, out_tag, out_value, out_ts, level, t0);
            end
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_value !== 64'(20 + k) || out_ts !== t0 + 32'(k)) begin
                errors++;
                $display("FAIL drain_%0d: got v=%0b val=%0d ts=%0d want 1/%0d/%0d",
                         k, out_valid, out_value, out_ts, 20 + k, t0 + 32'(k));
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_en_clr_wrap();
        logic [31:0] t_frozen;
        en = 1'b0; out_ready = 1'b0;
        in_a = 64'sd30; in_a_vld = 1'b1;
        t_frozen = ts_m;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (level !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_off_%0d: got lvl=%0d v=%0b want 0/0", c, level, out_valid);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (out_ts !== t_frozen || out_value !== 64'sd30) begin
            errors++;
            $display("FAIL ts_frozen: got ts=%0d val=%0d want %0d/30", out_ts, out_value, t_frozen);
        end
        for (int i = 1; i <= 4; i++) begin
            in_a = 64'(30 + i);
            step();
        end
        in_a_vld = 1'b0;
        checks++;
        if (level !== 4'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_clr: got lvl=%0d ovf=%0b want 5/1", level, overflow);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (level !== '0 || overflow !== 1'b0 || out_valid !== 1'b0 || out_value !== 64'sd30) begin
            errors++;
            $display("FAIL clr: got lvl=%0d ovf=%0b v=%0b val=%0d want 0/0/0/30",
                     level, overflow, out_valid, out_value);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && ts_m[3:0] != 4'd15; c++) step();
        in_a = 64'sd40; in_a_vld = 1'b1;
        step();
        checks++;
        if (w_out_ts !== 4'd15 || out_value !== 64'sd40) begin
            errors++;
            $display("FAIL wrap_15: got wts=%0d val=%0d want 15/40", w_out_ts, out_value);
        end
        in_a = 64'sd41;
        step();
        in_a_vld = 1'b0;
        checks++;
        if (w_out_ts !== 4'd0 || out_value !== 64'sd41) begin
            errors++;
            $display("FAIL wrap_0: got wts=%0d val=%0d want 0/41", w_out_ts, out_value);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        in_a = 64'sd50; in_b = 64'sd51; in_a_vld = 1'b1; in_b_vld = 1'b1;
        step();
        in_a_vld = 1'b0; in_b_vld = 1'b0;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || out_value !== '0 || out_ts !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b lvl=%0d val=%0d ts=%0d want all 0",
                     out_valid, level, out_value, out_ts);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_init();
        mon_en = 1'b1;
        out_ready = 1'b1;
        in_a = 64'sd60; in_a_vld = 1'b1;
        step();
        in_a_vld = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ts !== 32'd0 || out_value !== 64'sd60) begin
            errors++;
            $display("FAIL post_reset: got v=%0b ts=%0d val=%0d want 1/0/60", out_valid, out_ts, out_value);
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dual();
        test_full();
        test_full_pop();
        test_backpressure();
        test_en_clr_wrap();
        test_reset_midop();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
